// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: pipeline register addresses and enables in,
// forwarding selects and stage stall/flush controls out.
// HAZARD_PERF_CNT_EN adds the three performance counters (CNT_W bits each).
//
// Handshake note: the only handshake here is the data-memory one. The M stage
// raises mem_req while a load/store is in flight; mem_ready=1 in a cycle means
// the access completes in that cycle. mem_req=1 with mem_ready=0 holds the
// pipeline for that cycle; mem_ready is ignored when mem_req=0.
interface hazard_ctrl_unit_if #(
  parameter int REG_AW = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
);
  logic [REG_AW-1:0] IF_ID_rs1;
  logic [REG_AW-1:0] IF_ID_rs2;
  logic [REG_AW-1:0] ID_EX_rs1;
  logic [REG_AW-1:0] ID_EX_rs2;
  logic [REG_AW-1:0] ID_EX_rd;
  logic              ID_EX_is_load;
  logic [REG_AW-1:0] EX_MEM_rd;
  logic [REG_AW-1:0] MEM_WB_rd;
  logic              EX_MEM_regwrite_en;
  logic              MEM_WB_regwrite_en;
  logic              EX_MEM_mem_req;
  logic              mem_ready;
  logic              pcsrc_E;

  logic [1:0]        forwardAE;
  logic [1:0]        forwardBE;
  logic              stallF;
  logic              stallD;
  logic              stallE;
  logic              stallM;
  logic              flushD;
  logic              flushE;
  logic              flushW;
  logic              busy;
  logic [1:0]        state_dbg;
`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0]  perf_lu_stalls;
  logic [CNT_W-1:0]  perf_mem_stalls;
  logic [CNT_W-1:0]  perf_flushes;
`endif

  // Pipeline side: drives register/handshake info, consumes controls.
  modport master (
    output IF_ID_rs1, IF_ID_rs2, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_is_load,
    output EX_MEM_rd, MEM_WB_rd, EX_MEM_regwrite_en, MEM_WB_regwrite_en,
    output EX_MEM_mem_req, mem_ready, pcsrc_E,
    input  forwardAE, forwardBE, stallF, stallD, stallE, stallM,
    input  flushD, flushE, flushW, busy, state_dbg
`ifdef HAZARD_PERF_CNT_EN
    , input perf_lu_stalls, perf_mem_stalls, perf_flushes
`endif
  );

  // Hazard unit side.
  modport slave (
    input  IF_ID_rs1, IF_ID_rs2, ID_EX_rs1, ID_EX_rs2, ID_EX_rd, ID_EX_is_load,
    input  EX_MEM_rd, MEM_WB_rd, EX_MEM_regwrite_en, MEM_WB_regwrite_en,
    input  EX_MEM_mem_req, mem_ready, pcsrc_E,
    output forwardAE, forwardBE, stallF, stallD, stallE, stallM,
    output flushD, flushE, flushW, busy, state_dbg
`ifdef HAZARD_PERF_CNT_EN
    , output perf_lu_stalls, perf_mem_stalls, perf_flushes
`endif
  );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: EX operand forwarding plus all stall/flush control for the
// five-stage RV32I pipeline. Sources, highest priority first: data-memory wait,
// taken branch/jump in E, load-use dependence (held LOAD_LAT cycles).
// Optional feature macro: HAZARD_PERF_CNT_EN (saturating per-source counters).
// Reset: synchronous, active-low rst.
module hazard_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 32
) (
  input  logic           clk,
  input  logic           rst,
  hazard_ctrl_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_HOLD  = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

  // Reject out-of-range configurations at elaboration.
  if (LOAD_LAT < 1 || LOAD_LAT > 7 || CNT_W < 1) begin : g_bad_param
    $error("hazard_ctrl_unit: LOAD_LAT must be 1..7 and CNT_W >= 1");
  end

  state_t     state, next_state, eff_state;
  logic [2:0] lu_cnt, next_lu_cnt;

  logic       mem_wait, lu_hit;
  logic       lu_act, mem_act, br_act;
  logic [1:0] fwd_a, fwd_b;
  logic       m_hit_a, m_hit_b, w_hit_a, w_hit_b;

  assign mem_wait = hz.EX_MEM_mem_req & ~hz.mem_ready;
  assign lu_hit   = hz.ID_EX_is_load && (hz.ID_EX_rd != '0) &&
                    ((hz.ID_EX_rd == hz.IF_ID_rs1) || (hz.ID_EX_rd == hz.IF_ID_rs2));

  // When a memory wait ends, resume whichever state was interrupted: a saved
  // non-zero lu_cnt means a load-use hold was in progress.
  assign eff_state = (state == MEM_WAIT) ? ((lu_cnt != 3'd0) ? LU_HOLD : RUN) : state;

  // Forwarding selects: the M-stage result is younger, so it beats W.
  always_comb begin
    m_hit_a = hz.EX_MEM_regwrite_en && (hz.EX_MEM_rd != '0) && (hz.EX_MEM_rd == hz.ID_EX_rs1);
    m_hit_b = hz.EX_MEM_regwrite_en && (hz.EX_MEM_rd != '0) && (hz.EX_MEM_rd == hz.ID_EX_rs2);
    w_hit_a = hz.MEM_WB_regwrite_en && (hz.MEM_WB_rd != '0) && (hz.MEM_WB_rd == hz.ID_EX_rs1);
    w_hit_b = hz.MEM_WB_regwrite_en && (hz.MEM_WB_rd != '0) && (hz.MEM_WB_rd == hz.ID_EX_rs2);
    fwd_a   = 2'b00;
    fwd_b   = 2'b00;
    if (rst) begin
      if (m_hit_a)      fwd_a = 2'b10;
      else if (w_hit_a) fwd_a = 2'b01;
      if (m_hit_b)      fwd_b = 2'b10;
      else if (w_hit_b) fwd_b = 2'b01;
    end
  end

  assign hz.forwardAE = fwd_a;
  assign hz.forwardBE = fwd_b;

  // Stall/flush decode and next-state selection, in priority order.
  always_comb begin
    hz.stallF   = 1'b0;
    hz.stallD   = 1'b0;
    hz.stallE   = 1'b0;
    hz.stallM   = 1'b0;
    hz.flushD   = 1'b0;
    hz.flushE   = 1'b0;
    hz.flushW   = 1'b0;
    next_state  = state;
    next_lu_cnt = lu_cnt;
    lu_act      = 1'b0;
    mem_act     = 1'b0;
    br_act      = 1'b0;
    if (!rst) begin
      // Every stage register is cleared while reset is held.
      hz.flushD = 1'b1;
      hz.flushE = 1'b1;
      hz.flushW = 1'b1;
    end else if (mem_wait) begin
      // Freeze F..M and bubble W; lu_cnt is held so a hold can resume.
      hz.stallF  = 1'b1;
      hz.stallD  = 1'b1;
      hz.stallE  = 1'b1;
      hz.stallM  = 1'b1;
      hz.flushW  = 1'b1;
      mem_act    = 1'b1;
      next_state = MEM_WAIT;
    end else if (hz.pcsrc_E) begin
      // The dependent instruction is squashed, so any pending hold is dropped.
      hz.flushD   = 1'b1;
      hz.flushE   = 1'b1;
      br_act      = 1'b1;
      next_lu_cnt = 3'd0;
      next_state  = RUN;
    end else if (eff_state == LU_HOLD) begin
      hz.stallF   = 1'b1;
      hz.stallD   = 1'b1;
      hz.flushE   = 1'b1;
      lu_act      = 1'b1;
      next_lu_cnt = lu_cnt - 3'd1;
      next_state  = (lu_cnt == 3'd1) ? RUN : LU_HOLD;
    end else begin
      next_state = RUN;
      if (lu_hit) begin
        hz.stallF = 1'b1;
        hz.stallD = 1'b1;
        hz.flushE = 1'b1;
        lu_act    = 1'b1;
        if (LOAD_LAT > 1) begin
          next_lu_cnt = LU_INIT;
          next_state  = LU_HOLD;
        end
      end
    end
  end

  assign hz.busy      = rst && (state != RUN);
  assign hz.state_dbg = state;

  // State and load-use countdown registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= RUN;
      lu_cnt <= 3'd0;
    end else begin
      state  <= next_state;
      lu_cnt <= next_lu_cnt;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] cnt_lu, cnt_mem, cnt_fl;

  // Saturating per-source cycle counters.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_lu  <= '0;
      cnt_mem <= '0;
      cnt_fl  <= '0;
    end else begin
      if (lu_act  && (cnt_lu  != '1)) cnt_lu  <= cnt_lu  + CNT_W'(1);
      if (mem_act && (cnt_mem != '1)) cnt_mem <= cnt_mem + CNT_W'(1);
      if (br_act  && (cnt_fl  != '1)) cnt_fl  <= cnt_fl  + CNT_W'(1);
    end
  end

  assign hz.perf_lu_stalls  = cnt_lu;
  assign hz.perf_mem_stalls = cnt_mem;
  assign hz.perf_flushes    = cnt_fl;
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Directed bench for hazard_ctrl_unit (LOAD_LAT=2). Control outputs are packed
// as {stallF,stallD,stallE,stallM,flushD,flushE,flushW,busy} for comparison.
module tb_hazard_ctrl_unit;
  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 2;
  localparam int CNT_W    = 4;

  // Packed control values used throughout.
  localparam logic [7:0] C_IDLE  = 8'h00;
  localparam logic [7:0] C_RST   = 8'h0E;
  localparam logic [7:0] C_LU    = 8'hC4;
  localparam logic [7:0] C_LUH   = 8'hC5;
  localparam logic [7:0] C_MEM   = 8'hF2;
  localparam logic [7:0] C_MEMB  = 8'hF3;
  localparam logic [7:0] C_BR    = 8'h0C;
  localparam logic [7:0] C_BRB   = 8'h0D;
  localparam logic [7:0] C_MRDY  = 8'h01;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [7:0] exp_q[$];

  hazard_ctrl_unit_if #(
    .REG_AW(REG_AW)
`ifdef HAZARD_PERF_CNT_EN
    , .CNT_W(CNT_W)
`endif
  ) hz ();

  hazard_ctrl_unit #(
    .REG_AW(REG_AW),
    .LOAD_LAT(LOAD_LAT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .hz(hz)
  );

  logic [7:0] ctl;
  assign ctl = {hz.stallF, hz.stallD, hz.stallE, hz.stallM,
                hz.flushD, hz.flushE, hz.flushW, hz.busy};

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected-queue check for multi-cycle sequences.
  task automatic chk_q(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(ctl), 32'(e));
    end
  endtask

  task automatic clear_inputs();
    hz.IF_ID_rs1          = '0;
    hz.IF_ID_rs2          = '0;
    hz.ID_EX_rs1          = '0;
    hz.ID_EX_rs2          = '0;
    hz.ID_EX_rd           = '0;
    hz.ID_EX_is_load      = 1'b0;
    hz.EX_MEM_rd          = '0;
    hz.MEM_WB_rd          = '0;
    hz.EX_MEM_regwrite_en = 1'b0;
    hz.MEM_WB_regwrite_en = 1'b0;
    hz.EX_MEM_mem_req     = 1'b0;
    hz.mem_ready          = 1'b0;
    hz.pcsrc_E            = 1'b0;
  endtask

  // Advance past the next rising edge; inputs change just after it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_load_use();
    hz.ID_EX_is_load = 1'b1;
    hz.ID_EX_rd      = 5'd7;
    hz.IF_ID_rs2     = 5'd7;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    clear_inputs();
    rst = 1'b0;

    // Reset: outputs forced even with a forwarding match present.
    repeat (2) cyc();
    hz.EX_MEM_rd = 5'd5; hz.EX_MEM_regwrite_en = 1'b1; hz.ID_EX_rs1 = 5'd5;
    settle();
    chk("rst_fwdA", 32'(hz.forwardAE), 32'd0);
    chk("rst_ctl", 32'(ctl), 32'(C_RST));
    chk("rst_state", 32'(hz.state_dbg), 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    chk("rst_perf_mem", 32'(hz.perf_mem_stalls), 32'd0);
`endif
    rst = 1'b1;
    clear_inputs();
    cyc();

    // Forwarding
    hz.EX_MEM_rd = 5'd5; hz.MEM_WB_rd = 5'd5;
    hz.EX_MEM_regwrite_en = 1'b1; hz.MEM_WB_regwrite_en = 1'b1;
    hz.ID_EX_rs1 = 5'd5;
    settle();
    chk("fwd_m_beats_w", 32'(hz.forwardAE), 32'd2);
    chk("fwd_b_none", 32'(hz.forwardBE), 32'd0);
    chk("fwd_ctl_idle", 32'(ctl), 32'(C_IDLE));
    hz.EX_MEM_rd = 5'd0;
    settle();
    chk("fwd_w_only", 32'(hz.forwardAE), 32'd1);
    hz.MEM_WB_rd = 5'd0;
    settle();
    chk("fwd_rd0", 32'(hz.forwardAE), 32'd0);
    hz.ID_EX_rs2 = 5'd9; hz.EX_MEM_rd = 5'd9; hz.MEM_WB_rd = 5'd9;
    hz.EX_MEM_regwrite_en = 1'b0;
    settle();
    chk("fwd_b_m_no_we", 32'(hz.forwardBE), 32'd1);
    clear_inputs();
    cyc();

    // Load-use, rd=0: no stall
    hz.ID_EX_is_load = 1'b1;
    settle();
    chk("lu_rd0", 32'(ctl), 32'(C_IDLE));
    clear_inputs();
    cyc();

    // Load-use LOAD_LAT=2: two stall cycles, busy on the second
    drive_load_use();
    settle();
    chk("lu_c1", 32'(ctl), 32'(C_LU));
    cyc();
    clear_inputs();
    settle();
    chk("lu_c2", 32'(ctl), 32'(C_LUH));
    chk("lu_state_hold", 32'(hz.state_dbg), 32'd1);
    cyc();
    settle();
    chk("lu_done", 32'(ctl), 32'(C_IDLE));
    chk("lu_state_run", 32'(hz.state_dbg), 32'd0);

    // Memory wait, 3 cycles of mem_ready low
    exp_q.push_back(C_MEM);
    exp_q.push_back(C_MEMB);
    exp_q.push_back(C_MEMB);
    exp_q.push_back(C_MRDY);
    for (int i = 0; i < 4; i++) begin
      hz.EX_MEM_mem_req = 1'b1;
      hz.mem_ready      = (i == 3);
      settle();
      chk_q("mem_wait");
      cyc();
    end
    clear_inputs();
    settle();
    chk("mem_after", 32'(ctl), 32'(C_IDLE));
    chk("mem_state_run", 32'(hz.state_dbg), 32'd0);

    // Branch with simultaneous load-use: flush wins, no stall, stays RUN
    drive_load_use();
    hz.pcsrc_E = 1'b1;
    settle();
    chk("br_lu", 32'(ctl), 32'(C_BR));
    cyc();
    clear_inputs();
    settle();
    chk("br_lu_after", 32'(ctl), 32'(C_IDLE));
    chk("br_lu_state", 32'(hz.state_dbg), 32'd0);

    // Branch during memory wait: flush only in the mem_ready cycle
    exp_q.push_back(C_MEM);
    exp_q.push_back(C_MEMB);
    exp_q.push_back(C_BRB);
    for (int i = 0; i < 3; i++) begin
      hz.EX_MEM_mem_req = 1'b1;
      hz.pcsrc_E        = 1'b1;
      hz.mem_ready      = (i == 2);
      settle();
      chk_q("br_mem");
      cyc();
    end
    clear_inputs();
    settle();
    chk("br_mem_after", 32'(ctl), 32'(C_IDLE));

    // Memory wait inside LU_HOLD freezes the countdown, hold resumes after
    drive_load_use();
    settle();
    chk("lu_mem_c1", 32'(ctl), 32'(C_LU));
    cyc();
    clear_inputs();
    hz.EX_MEM_mem_req = 1'b1;
    settle();
    chk("lu_mem_wait", 32'(ctl), 32'(C_MEMB));
    cyc();
    hz.mem_ready = 1'b1;
    settle();
    chk("lu_mem_resume", 32'(ctl), 32'(C_LUH));
    cyc();
    clear_inputs();
    settle();
    chk("lu_mem_done", 32'(ctl), 32'(C_IDLE));
    chk("lu_mem_state", 32'(hz.state_dbg), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
    // Per-source cycle totals since reset: lu 2+2, mem 3+2+1, flush 1+1
    chk("perf_lu", 32'(hz.perf_lu_stalls), 32'd4);
    chk("perf_mem", 32'(hz.perf_mem_stalls), 32'd6);
    chk("perf_fl", 32'(hz.perf_flushes), 32'd2);
    // Saturation: 20 more wait cycles must stop at 15
    for (int i = 0; i < 20; i++) begin
      hz.EX_MEM_mem_req = 1'b1;
      cyc();
    end
    hz.mem_ready = 1'b1;
    settle();
    chk("perf_mem_sat", 32'(hz.perf_mem_stalls), 32'd15);
    cyc();
    clear_inputs();
    cyc();
`endif

    // Reset abort in the middle of LU_HOLD
    drive_load_use();
    settle();
    chk("abort_c1", 32'(ctl), 32'(C_LU));
    cyc();
    clear_inputs();
    rst = 1'b0;
    hz.EX_MEM_rd = 5'd5; hz.EX_MEM_regwrite_en = 1'b1; hz.ID_EX_rs1 = 5'd5;
    settle();
    chk("abort_during_ctl", 32'(ctl), 32'(C_RST));
    chk("abort_during_fwd", 32'(hz.forwardAE), 32'd0);
    cyc();
    chk("abort_state", 32'(hz.state_dbg), 32'd0);
    chk("abort_ctl", 32'(ctl), 32'(C_RST));
`ifdef HAZARD_PERF_CNT_EN
    chk("abort_perf_lu", 32'(hz.perf_lu_stalls), 32'd0);
    chk("abort_perf_mem", 32'(hz.perf_mem_stalls), 32'd0);
`endif
    rst = 1'b1;
    clear_inputs();
    settle();
    chk("abort_after", 32'(ctl), 32'(C_IDLE));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Parametrised hazard controller for the pipelined RV32I core, superseding the forwarding-only unit. It produces EX-stage operand forwarding selects and owns all pipeline stall and flush control. Stall/flush sources are load-use dependences with configurable load latency, a multi-cycle data-memory handshake, and taken branches/jumps resolved in EX. It sits beside the five pipeline registers and drives their enable/clear inputs.

## Interface
- `REG_AW`, 5: register-address width.
- `LOAD_LAT`, 1: bubbles required between a load in EX and a dependent consumer (1..7).
- `CNT_W`, 32: performance-counter width (used only with the macro).

- `clk`  in  1  core clock, rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `IF_ID_rs1`, `IF_ID_rs2`  in  REG_AW  source registers of the instruction in D.
- `ID_EX_rs1`, `ID_EX_rs2`  in  REG_AW  source registers of the instruction in E.
- `ID_EX_rd`  in  REG_AW  destination of E; `ID_EX_is_load`  in  1.
- `EX_MEM_rd`, `MEM_WB_rd`  in  REG_AW; `EX_MEM_regwrite_en`, `MEM_WB_regwrite_en`  in  1.
- `EX_MEM_mem_req`  in  1  load/store active in M; `mem_ready`  in  1  data memory done this cycle.
- `pcsrc_E`  in  1  taken branch/jump resolved in E.
- `forwardAE`, `forwardBE`  out  2  00 regfile, 10 from M, 01 from W.
- `stallF`, `stallD`, `stallE`, `stallM`  out  1  hold stage register.
- `flushD`, `flushE`, `flushW`  out  1  clear stage register to a bubble.
- `busy`  out  1  FSM not in RUN.

## Operation
- Forwarding (combinational, E operands): M match beats W match; a match requires regwrite_en=1, rd≠0, rd==rs. While `rst`=0, both selects are 00.
- FSM states: RUN, LU_HOLD, MEM_WAIT. Internal 3-bit counter `lu_cnt`.
- Priority when sources coincide: MEM_WAIT condition > branch flush > load-use.
- Memory wait: `EX_MEM_mem_req`=1 and `mem_ready`=0, evaluated in any state. Outputs stallF/D/E/M=1 and flushW=1; no other flushes. The FSM enters or stays in MEM_WAIT. When `mem_ready` rises, it returns to RUN, or to LU_HOLD if `lu_cnt`≠0 was saved.
- Branch: `pcsrc_E`=1 with no memory wait. Outputs flushD=1 and flushE=1 for one cycle. Any pending load-use hold is cancelled (`lu_cnt`←0), because the dependent instruction is squashed.
- Load-use, detected in RUN: `ID_EX_is_load`=1, `ID_EX_rd`≠0, and `ID_EX_rd` equals `IF_ID_rs1` or `IF_ID_rs2`.
  - Same cycle: stallF=1, stallD=1, flushE=1.
  - If LOAD_LAT>1: `lu_cnt`←LOAD_LAT−1 and the FSM goes to LU_HOLD.
- LU_HOLD: stallF=stallD=flushE=1 each cycle and `lu_cnt` decrements. Returns to RUN after the cycle in which `lu_cnt`==1.
- A memory wait arising in LU_HOLD freezes `lu_cnt`.
- `busy`=1 whenever the state is not RUN.

## Timing
- Forward selects and all stall/flush outputs are combinational from inputs and current state, with zero latency. State and `lu_cnt` update on the rising `clk` edge.
- Reset (`rst`=0 at an edge): state←RUN, `lu_cnt`←0, counters←0.
  - While `rst`=0: forward=00, all stalls=0, flushD=flushE=flushW=1, busy=0.
  - Reset mid-MEM_WAIT or mid-LU_HOLD aborts immediately.
- A load-use stall costs exactly LOAD_LAT cycles of stallD. A memory wait lasts as many cycles as `mem_ready` is low.
- A branch in E during a memory wait is applied in the cycle `mem_ready`=1, since E is held and `pcsrc_E` stays asserted.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: adds outputs `perf_lu_stalls`, `perf_mem_stalls`, `perf_flushes` (CNT_W each).
  - Each counter increments once per cycle in which its source is the active one.
  - Each saturates at all-ones and is cleared by reset.
- Macro undefined: these ports and their logic are absent; all other behaviour is identical.

## Test plan
- Forwarding: EX_MEM_rd=MEM_WB_rd=5, both regwrite=1, ID_EX_rs1=5 -> forwardAE=10. Same with EX_MEM_rd=0 -> forwardAE=01. Both rd=0 -> 00.
- Load-use with LOAD_LAT=2: `ID_EX_is_load`=1, rd=7, IF_ID_rs2=7 -> stallF/stallD/flushE high for exactly 2 cycles with busy=1 on the 2nd, then RUN. rd=0 -> no stall.
- Memory wait: mem_req=1 with mem_ready low for 3 cycles -> stallF..M and flushW high for 3 cycles. Outputs drop in the cycle mem_ready=1.
- Simultaneous events: pcsrc_E=1 together with a load-use match -> flushD=flushE=1 for one cycle, no stallD, state stays RUN. pcsrc_E during a memory wait -> flush only in the mem_ready cycle.
- Reset abort: rst=0 in the middle of LU_HOLD -> next cycle state RUN, forward=00, flushes=1, busy=0.
- With `HAZARD_PERF_CNT_EN`: after the scenarios above, counters match the expected per-source cycle counts. Preloading CNT_W=4 to saturation -> counter holds at 15.
